// File: rtl/pad_gpio_ctrl.sv
// GPIO pad controller: registered pad drive/tristate, synchronised and
// glitch-filtered pad input with edge pulses and sticky edge interrupts.
module pad_gpio_ctrl #(
    parameter int WIDTH  = 16,
    parameter int FILT_W = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [WIDTH-1:0]  out_data,
    input  logic [WIDTH-1:0]  out_en,
    output logic [WIDTH-1:0]  pad_o,
    output logic [WIDTH-1:0]  pad_t,
    input  logic [WIDTH-1:0]  pad_i,
    input  logic [FILT_W-1:0] filt_cfg,
    output logic [WIDTH-1:0]  in_data,
    output logic [WIDTH-1:0]  rise_pulse,
    output logic [WIDTH-1:0]  fall_pulse,
    input  logic [WIDTH-1:0]  irq_en,
    input  logic [WIDTH-1:0]  irq_clr,
    output logic [WIDTH-1:0]  irq_status,
    output logic              irq
);

    logic [WIDTH-1:0]             s1;
    logic [WIDTH-1:0]             s2;
    logic [WIDTH-1:0][FILT_W-1:0] cnt;

    // Output path; pads stay tristated while in reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pad_o <= '0;
            pad_t <= '1;
        end else begin
            pad_o <= out_data;
            pad_t <= ~out_en;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pad_i;
            s2 <= s1;
        end
    end

    // The >= compare keeps cnt bounded by filt_cfg even if the threshold
    // is lowered mid-count, so the counter can never wrap.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            in_data    <= '0;
            cnt        <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] != in_data[i]) begin
                    if (cnt[i] >= filt_cfg) begin
                        in_data[i]    <= s2[i];
                        cnt[i]        <= '0;
                        rise_pulse[i] <= s2[i];
                        fall_pulse[i] <= ~s2[i];
                    end else begin
                        cnt[i] <= cnt[i] + FILT_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // A new edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | ((rise_pulse | fall_pulse) & irq_en);
        end
    end

    assign irq = |irq_status;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// Self-checking bench for pad_gpio_ctrl: directed reset, output, filter,
// interrupt and asynchronous-reset scenarios with an expected-value queue.
module tb_pad_gpio_ctrl;

    localparam int W = 48;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [15:0] out_data, out_en, pad_o, pad_t, pad_i;
    logic [3:0]  filt_cfg;
    logic [15:0] in_data, rise_pulse, fall_pulse, irq_en, irq_clr, irq_status;
    logic        irq;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    pad_gpio_ctrl #(.WIDTH(16), .FILT_W(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .out_data(out_data), .out_en(out_en), .pad_o(pad_o), .pad_t(pad_t),
        .pad_i(pad_i), .filt_cfg(filt_cfg),
        .in_data(in_data), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .irq_en(irq_en), .irq_clr(irq_clr), .irq_status(irq_status), .irq(irq)
    );

    // clock / watchdog
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Pops one expectation and compares it with {in_data, rise, fall}.
    task automatic sb_compare(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=empty_queue exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, {in_data, rise_pulse, fall_pulse}, e);
        end
    endtask

    function automatic logic [W-1:0] pack_exp(input logic [15:0] ind, input logic [15:0] r,
                                              input logic [15:0] f);
        return {ind, r, f};
    endfunction

    // Bit 0 pulse of hi_len cycles with threshold cfg; all other pads low.
    task automatic filter_run(input int cfg, input int hi_len, input string tag);
        int  n, rk, fk;
        bit  acc;
        logic [15:0] ind, r, f;
        filt_cfg = 4'(cfg);
        n   = hi_len + cfg + 6;
        acc = (hi_len >= cfg + 1);
        rk  = cfg + 3;
        fk  = hi_len + cfg + 3;
        for (int k = 1; k <= n; k++) begin
            ind = '0; r = '0; f = '0;
            ind[0] = acc && (k >= rk) && (k < fk);
            r[0]   = acc && (k == rk);
            f[0]   = acc && (k == fk);
            exp_q.push_back(pack_exp(ind, r, f));
        end
        pad_i[0] = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step();
            sb_compare(tag);
            if (k == hi_len) pad_i[0] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] d, e;

        // reset with pads high and drivers enabled
        HRESETn  = 1'b0;
        out_data = '0;
        out_en   = 16'hFFFF;
        pad_i    = 16'hFFFF;
        filt_cfg = 4'd0;
        irq_en   = '0;
        irq_clr  = '0;
        #25;
        check("rst_pad_t",   48'(pad_t),   48'hFFFF);
        check("rst_pad_o",   48'(pad_o),   48'h0);
        check("rst_in_data", 48'(in_data), 48'h0);
        check("rst_irq",     48'(irq),     48'h0);

        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int k = 1; k <= 4; k++)
            exp_q.push_back(pack_exp((k >= 3) ? 16'hFFFF : 16'h0,
                                     (k == 3) ? 16'hFFFF : 16'h0, 16'h0));
        for (int k = 1; k <= 4; k++) begin
            step();
            sb_compare("rel_rise");
            if (k == 1) check("rel_pad_t", 48'(pad_t), 48'h0);
        end

        pad_i = '0;
        repeat (6) step();
        check("pads_low", 48'(in_data), 48'h0);

        // output path
        out_en   = 16'h00FF;
        out_data = 16'hA5A5;
        step();
        check("out_dir", {16'h0, pad_t, pad_o}, {16'h0, 16'hFF00, 16'hA5A5});
        for (int j = 0; j < 12; j++) begin
            d = 16'($urandom_range(0, 65535));
            e = 16'($urandom_range(0, 65535));
            out_data = d;
            out_en   = e;
            exp_q.push_back({16'h0, ~e, d});
            step();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_rand got=empty_queue exp=entry");
            end else begin
                check("out_rand", {16'h0, pad_t, pad_o}, exp_q.pop_front());
            end
        end

        // glitch filter on bit 0
        filter_run(3, 3, "filt3_glitch");
        filter_run(3, 4, "filt3_accept");
        filter_run(3, 7, "filt3_long");
        filter_run(0, 1, "filt0_pass");
        filter_run(15, 15, "filt15_glitch");
        filter_run(15, 16, "filt15_accept");

        // interrupts on bit 0 only
        filt_cfg = 4'd0;
        irq_en   = 16'h0001;
        pad_i    = 16'h0003;
        repeat (3) step();
        check("irq_rise", 48'(rise_pulse), 48'h0003);
        check("irq_not_yet", 48'(irq_status), 48'h0);
        step();
        check("irq_set", {31'h0, irq, irq_status}, {31'h0, 1'b1, 16'h0001});
        pad_i = 16'h0000;
        repeat (3) step();
        check("irq_fall", 48'(fall_pulse), 48'h0003);
        irq_clr = 16'h0001;
        step();
        check("irq_set_wins", 48'(irq_status), 48'h0001);
        irq_clr = '0;
        step();
        check("irq_sticky", 48'(irq_status), 48'h0001);
        irq_clr = 16'h0001;
        step();
        irq_clr = '0;
        check("irq_clear", {31'h0, irq, irq_status}, 48'h0);

        // asynchronous reset during a filter count
        irq_en   = 16'hFFFF;
        out_data = 16'h1234;
        out_en   = 16'hF0F0;
        pad_i    = 16'h0002;
        repeat (4) step();
        check("pre_rst_irq", {31'h0, irq, irq_status}, {31'h0, 1'b1, 16'h0002});
        filt_cfg = 4'd5;
        pad_i    = 16'h0003;
        repeat (3) step();
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_pad", {16'h0, pad_t, pad_o}, {16'h0, 16'hFFFF, 16'h0});
        check("async_in",  {in_data, rise_pulse, fall_pulse}, 48'h0);
        check("async_irq", {31'h0, irq, irq_status}, 48'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int k = 1; k <= 9; k++)
            exp_q.push_back(pack_exp((k >= 8) ? 16'h0003 : 16'h0,
                                     (k == 8) ? 16'h0003 : 16'h0, 16'h0));
        for (int k = 1; k <= 9; k++) begin
            step();
            sb_compare("post_rst_rise");
        end
        check("post_rst_irq", {31'h0, irq, irq_status}, {31'h0, 1'b1, 16'h0003});
        check("queue_drained", 48'(exp_q.size()), 48'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
